bdu_bit_streamer: RTL and testbench

//  Upstream feeder for the BDU. Accepts one query/reference point pair (x,y,z, B bits/axis) per handshake.

---
 rtl/bdu_bit_streamer.sv | 369 ++++++++++++++++++++++++++++++++++++
 tb/tb_bdu_bit_streamer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/bdu_bit_streamer.sv
// Serialises one query/reference point pair MSB-first into the BDU's interleaved x,y,z bit stream.
// Optional one-entry pending buffer enabled by defining STREAMER_PREFETCH_EN.
module bdu_bit_streamer #(
    parameter int unsigned B            = 32,
    parameter int unsigned ID_W         = 16,
    parameter int unsigned DONE_TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [B-1:0]         in_q_x,
    input  logic [B-1:0]         in_q_y,
    input  logic [B-1:0]         in_q_z,
    input  logic [B-1:0]         in_r_x,
    input  logic [B-1:0]         in_r_y,
    input  logic [B-1:0]         in_r_z,
    input  logic [B-1:0]         in_threshold,
    input  logic [ID_W-1:0]      in_ref_id,
    output logic                 bdu_clear,
    output logic                 out_valid,
    output logic                 out_q_bit,
    output logic                 out_r_bit,
    output logic [1:0]           out_code,
    output logic [$clog2(B)-1:0] out_b,
    output logic [B-1:0]         out_threshold,
    output logic [ID_W-1:0]      out_ref_id,
    output logic                 out_last,
    input  logic                 bdu_terminate,
    input  logic                 bdu_done,
    output logic [15:0]          abort_count,
    output logic                 timeout_err
);

    localparam int unsigned PW = $clog2(B);
    localparam int unsigned TW = $clog2(DONE_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_CLEAR     = 2'd1,
        S_STREAM    = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t            r_state;
    logic [PW-1:0]     r_plane;
    logic [1:0]        r_axis;
    logic [TW-1:0]     r_wait;
    logic [B-1:0]      r_q_x;
    logic [B-1:0]      r_q_y;
    logic [B-1:0]      r_q_z;
    logic [B-1:0]      r_r_x;
    logic [B-1:0]      r_r_y;
    logic [B-1:0]      r_r_z;
    logic [B-1:0]      r_thr;
    logic [ID_W-1:0]   r_id;
    logic              r_in_ready;
    logic              r_clear;
    logic              r_valid;
    logic              r_q_bit;
    logic              r_r_bit;
    logic [1:0]        r_code;
    logic [PW-1:0]     r_b;
    logic              r_last;
    logic [15:0]       r_abort_cnt;
    logic              r_timeout_err;

    state_t            w_state_nxt;
    logic [PW-1:0]     w_plane_nxt;
    logic [1:0]        w_axis_nxt;
    logic [TW-1:0]     w_wait_nxt;
    logic [B-1:0]      w_q_x_nxt;
    logic [B-1:0]      w_q_y_nxt;
    logic [B-1:0]      w_q_z_nxt;
    logic [B-1:0]      w_r_x_nxt;
    logic [B-1:0]      w_r_y_nxt;
    logic [B-1:0]      w_r_z_nxt;
    logic [B-1:0]      w_thr_nxt;
    logic [ID_W-1:0]   w_id_nxt;
    logic              w_in_ready_nxt;
    logic              w_clear_nxt;
    logic              w_valid_nxt;
    logic              w_q_bit_nxt;
    logic              w_r_bit_nxt;
    logic [1:0]        w_code_nxt;
    logic [PW-1:0]     w_b_nxt;
    logic              w_last_nxt;
    logic [15:0]       w_abort_nxt;
    logic              w_timeout_nxt;
    logic              w_accept;
    logic              w_emit;
    logic              w_leave;
    logic [PW-1:0]     w_bit_idx;
    logic [B-1:0]      w_q_word;
    logic [B-1:0]      w_r_word;

`ifdef STREAMER_PREFETCH_EN
    logic              r_pend_full;
    logic [B-1:0]      r_pend_q_x;
    logic [B-1:0]      r_pend_q_y;
    logic [B-1:0]      r_pend_q_z;
    logic [B-1:0]      r_pend_r_x;
    logic [B-1:0]      r_pend_r_y;
    logic [B-1:0]      r_pend_r_z;
    logic [B-1:0]      r_pend_thr;
    logic [ID_W-1:0]   r_pend_id;
    logic              w_pend_full_nxt;
    logic [B-1:0]      w_pend_q_x_nxt;
    logic [B-1:0]      w_pend_q_y_nxt;
    logic [B-1:0]      w_pend_q_z_nxt;
    logic [B-1:0]      w_pend_r_x_nxt;
    logic [B-1:0]      w_pend_r_y_nxt;
    logic [B-1:0]      w_pend_r_z_nxt;
    logic [B-1:0]      w_pend_thr_nxt;
    logic [ID_W-1:0]   w_pend_id_nxt;
`endif

    // Next-state, datapath and registered-output values
    always_comb begin
        w_state_nxt    = r_state;
        w_plane_nxt    = r_plane;
        w_axis_nxt     = r_axis;
        w_wait_nxt     = r_wait;
        w_q_x_nxt      = r_q_x;
        w_q_y_nxt      = r_q_y;
        w_q_z_nxt      = r_q_z;
        w_r_x_nxt      = r_r_x;
        w_r_y_nxt      = r_r_y;
        w_r_z_nxt      = r_r_z;
        w_thr_nxt      = r_thr;
        w_id_nxt       = r_id;
        w_in_ready_nxt = 1'b0;
        w_clear_nxt    = 1'b0;
        w_valid_nxt    = 1'b0;
        w_q_bit_nxt    = 1'b0;
        w_r_bit_nxt    = 1'b0;
        w_code_nxt     = 2'd0;
        w_b_nxt        = '0;
        w_last_nxt     = 1'b0;
        w_abort_nxt    = r_abort_cnt;
        w_timeout_nxt  = r_timeout_err;
        w_accept       = in_valid && r_in_ready;
        w_emit         = 1'b0;
        w_leave        = 1'b0;
        w_bit_idx      = '0;
        w_q_word       = '0;
        w_r_word       = '0;
`ifdef STREAMER_PREFETCH_EN
        w_pend_full_nxt = r_pend_full;
        w_pend_q_x_nxt  = r_pend_q_x;
        w_pend_q_y_nxt  = r_pend_q_y;
        w_pend_q_z_nxt  = r_pend_q_z;
        w_pend_r_x_nxt  = r_pend_r_x;
        w_pend_r_y_nxt  = r_pend_r_y;
        w_pend_r_z_nxt  = r_pend_r_z;
        w_pend_thr_nxt  = r_pend_thr;
        w_pend_id_nxt   = r_pend_id;
`endif

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_CLEAR;
                    w_clear_nxt = 1'b1;
                    w_q_x_nxt   = in_q_x;
                    w_q_y_nxt   = in_q_y;
                    w_q_z_nxt   = in_q_z;
                    w_r_x_nxt   = in_r_x;
                    w_r_y_nxt   = in_r_y;
                    w_r_z_nxt   = in_r_z;
                    w_thr_nxt   = in_threshold;
                    w_id_nxt    = in_ref_id;
                end
            end
            S_CLEAR: begin
                w_state_nxt = S_STREAM;
                w_plane_nxt = '0;
                w_axis_nxt  = 2'd0;
                w_emit      = 1'b1;
            end
            S_STREAM: begin
                // Terminate wins over the last-beat transition, so it is always an abort
                if (bdu_terminate) begin
                    w_leave = 1'b1;
                    if (r_abort_cnt != 16'hFFFF) begin
                        w_abort_nxt = r_abort_cnt + 16'd1;
                    end
                end else if ((r_plane == PW'(B - 1)) && (r_axis == 2'd2)) begin
                    w_state_nxt = S_WAIT_DONE;
                    w_wait_nxt  = '0;
                end else begin
                    w_emit = 1'b1;
                    if (r_axis == 2'd2) begin
                        w_axis_nxt  = 2'd0;
                        w_plane_nxt = r_plane + PW'(1);
                    end else begin
                        w_axis_nxt  = r_axis + 2'd1;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (bdu_done || bdu_terminate) begin
                    w_leave = 1'b1;
                end else if (r_wait == TW'(DONE_TIMEOUT - 1)) begin
                    w_leave       = 1'b1;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_wait_nxt = r_wait + TW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_leave) begin
            w_state_nxt = S_IDLE;
        end

`ifdef STREAMER_PREFETCH_EN
        // A buffered or arriving pair skips the idle cycle and goes straight to CLEAR
        if (w_leave && r_pend_full) begin
            w_state_nxt     = S_CLEAR;
            w_clear_nxt     = 1'b1;
            w_pend_full_nxt = 1'b0;
            w_q_x_nxt       = r_pend_q_x;
            w_q_y_nxt       = r_pend_q_y;
            w_q_z_nxt       = r_pend_q_z;
            w_r_x_nxt       = r_pend_r_x;
            w_r_y_nxt       = r_pend_r_y;
            w_r_z_nxt       = r_pend_r_z;
            w_thr_nxt       = r_pend_thr;
            w_id_nxt        = r_pend_id;
        end else if (w_leave && w_accept) begin
            w_state_nxt = S_CLEAR;
            w_clear_nxt = 1'b1;
            w_q_x_nxt   = in_q_x;
            w_q_y_nxt   = in_q_y;
            w_q_z_nxt   = in_q_z;
            w_r_x_nxt   = in_r_x;
            w_r_y_nxt   = in_r_y;
            w_r_z_nxt   = in_r_z;
            w_thr_nxt   = in_threshold;
            w_id_nxt    = in_ref_id;
        end else if (w_accept && (r_state != S_IDLE)) begin
            w_pend_full_nxt = 1'b1;
            w_pend_q_x_nxt  = in_q_x;
            w_pend_q_y_nxt  = in_q_y;
            w_pend_q_z_nxt  = in_q_z;
            w_pend_r_x_nxt  = in_r_x;
            w_pend_r_y_nxt  = in_r_y;
            w_pend_r_z_nxt  = in_r_z;
            w_pend_thr_nxt  = in_threshold;
            w_pend_id_nxt   = in_ref_id;
        end
        w_in_ready_nxt = !w_pend_full_nxt;
`else
        w_in_ready_nxt = (w_state_nxt == S_IDLE);
`endif

        // Beat payload for the plane/axis about to be shown
        if (w_emit) begin
            w_bit_idx = PW'(B - 1) - w_plane_nxt;
            case (w_axis_nxt)
                2'd0:    begin w_q_word = r_q_x; w_r_word = r_r_x; end
                2'd1:    begin w_q_word = r_q_y; w_r_word = r_r_y; end
                default: begin w_q_word = r_q_z; w_r_word = r_r_z; end
            endcase
            w_valid_nxt = 1'b1;
            w_q_bit_nxt = w_q_word[w_bit_idx];
            w_r_bit_nxt = w_r_word[w_bit_idx];
            w_code_nxt  = w_axis_nxt + 2'd1;
            w_b_nxt     = w_plane_nxt + PW'(1);
            w_last_nxt  = (w_plane_nxt == PW'(B - 1)) && (w_axis_nxt == 2'd2);
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_plane       <= '0;
            r_axis        <= 2'd0;
            r_wait        <= '0;
            r_q_x         <= '0;
            r_q_y         <= '0;
            r_q_z         <= '0;
            r_r_x         <= '0;
            r_r_y         <= '0;
            r_r_z         <= '0;
            r_thr         <= '0;
            r_id          <= '0;
            r_in_ready    <= 1'b1;
            r_clear       <= 1'b0;
            r_valid       <= 1'b0;
            r_q_bit       <= 1'b0;
            r_r_bit       <= 1'b0;
            r_code        <= 2'd0;
            r_b           <= '0;
            r_last        <= 1'b0;
            r_abort_cnt   <= 16'd0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_plane       <= w_plane_nxt;
            r_axis        <= w_axis_nxt;
            r_wait        <= w_wait_nxt;
            r_q_x         <= w_q_x_nxt;
            r_q_y         <= w_q_y_nxt;
            r_q_z         <= w_q_z_nxt;
            r_r_x         <= w_r_x_nxt;
            r_r_y         <= w_r_y_nxt;
            r_r_z         <= w_r_z_nxt;
            r_thr         <= w_thr_nxt;
            r_id          <= w_id_nxt;
            r_in_ready    <= w_in_ready_nxt;
            r_clear       <= w_clear_nxt;
            r_valid       <= w_valid_nxt;
            r_q_bit       <= w_q_bit_nxt;
            r_r_bit       <= w_r_bit_nxt;
            r_code        <= w_code_nxt;
            r_b           <= w_b_nxt;
            r_last        <= w_last_nxt;
            r_abort_cnt   <= w_abort_nxt;
            r_timeout_err <= w_timeout_nxt;
        end
    end

`ifdef STREAMER_PREFETCH_EN
    // Pending-pair buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_full <= 1'b0;
            r_pend_q_x  <= '0;
            r_pend_q_y  <= '0;
            r_pend_q_z  <= '0;
            r_pend_r_x  <= '0;
            r_pend_r_y  <= '0;
            r_pend_r_z  <= '0;
            r_pend_thr  <= '0;
            r_pend_id   <= '0;
        end else begin
            r_pend_full <= w_pend_full_nxt;
            r_pend_q_x  <= w_pend_q_x_nxt;
            r_pend_q_y  <= w_pend_q_y_nxt;
            r_pend_q_z  <= w_pend_q_z_nxt;
            r_pend_r_x  <= w_pend_r_x_nxt;
            r_pend_r_y  <= w_pend_r_y_nxt;
            r_pend_r_z  <= w_pend_r_z_nxt;
            r_pend_thr  <= w_pend_thr_nxt;
            r_pend_id   <= w_pend_id_nxt;
        end
    end
`endif

    assign in_ready      = r_in_ready;
    assign bdu_clear     = r_clear;
    assign out_valid     = r_valid;
    assign out_q_bit     = r_q_bit;
    assign out_r_bit     = r_r_bit;
    assign out_code      = r_code;
    assign out_b         = r_b;
    assign out_threshold = r_thr;
    assign out_ref_id    = r_id;
    assign out_last      = r_last;
    assign abort_count   = r_abort_cnt;
    assign timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_bdu_bit_streamer.sv
// Directed bench for bdu_bit_streamer (B=32, ID_W=16, DONE_TIMEOUT=8); honours STREAMER_PREFETCH_EN.
module tb_bdu_bit_streamer;

    localparam int unsigned B            = 32;
    localparam int unsigned ID_W         = 16;
    localparam int unsigned DONE_TIMEOUT = 8;
`ifdef STREAMER_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [B-1:0]    in_q_x, in_q_y, in_q_z;
    logic [B-1:0]    in_r_x, in_r_y, in_r_z;
    logic [B-1:0]    in_threshold;
    logic [ID_W-1:0] in_ref_id;
    logic            bdu_clear;
    logic            out_valid, out_q_bit, out_r_bit;
    logic [1:0]      out_code;
    logic [4:0]      out_b;
    logic [B-1:0]    out_threshold;
    logic [ID_W-1:0] out_ref_id;
    logic            out_last;
    logic            bdu_terminate, bdu_done;
    logic [15:0]     abort_count;
    logic            timeout_err;

    int n_vec  = 0;
    int n_miss = 0;
    logic [10:0] ab_q;

    bdu_bit_streamer #(.B(B), .ID_W(ID_W), .DONE_TIMEOUT(DONE_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_q_x(in_q_x), .in_q_y(in_q_y), .in_q_z(in_q_z),
        .in_r_x(in_r_x), .in_r_y(in_r_y), .in_r_z(in_r_z),
        .in_threshold(in_threshold), .in_ref_id(in_ref_id),
        .bdu_clear(bdu_clear), .out_valid(out_valid), .out_q_bit(out_q_bit),
        .out_r_bit(out_r_bit), .out_code(out_code), .out_b(out_b),
        .out_threshold(out_threshold), .out_ref_id(out_ref_id), .out_last(out_last),
        .bdu_terminate(bdu_terminate), .bdu_done(bdu_done),
        .abort_count(abort_count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_pair(input logic [31:0] qx, input logic [31:0] qy, input logic [31:0] qz,
                            input logic [31:0] rx, input logic [31:0] ry, input logic [31:0] rz,
                            input logic [31:0] thr, input logic [15:0] id);
        in_q_x = qx; in_q_y = qy; in_q_z = qz;
        in_r_x = rx; in_r_y = ry; in_r_z = rz;
        in_threshold = thr; in_ref_id = id;
    endtask

    // Ticks through beats first..last checking valid/code/plane tag/last
    task automatic run_beats(input string tag, input int first, input int last);
        for (int k = first; k <= last; k++) begin
            tick();
            chk(tag, {out_valid, out_code, out_b, out_last},
                {1'b1, 2'(k % 3 + 1), 5'((k / 3 + 1) % 32), 1'(k == 95)});
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; bdu_terminate = 1'b0; bdu_done = 1'b0;
        set_pair(0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("reset_ctl", {in_ready, bdu_clear, out_valid, out_q_bit, out_r_bit, out_code, out_b, out_last, timeout_err},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0});
        chk("reset_abort", abort_count, 16'd0);
        chk("reset_thr", {out_threshold, out_ref_id}, 48'd0);

        // Sanity stream with checked payload bits
        set_pair(32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF, 32'h0000FFF0, 32'h0000FFF0, 32'h0000FFF0, 32'h1234_5678, 16'hBEEF);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t1_clear", {bdu_clear, out_valid, in_ready}, {1'b1, 1'b0, PF});
        chk("t1_latch", {out_threshold, out_ref_id}, {32'h1234_5678, 16'hBEEF});
        for (int k = 0; k < 96; k++) begin
            tick();
            chk("t1_beat", {bdu_clear, out_valid, out_code, out_q_bit, out_r_bit, out_b, out_last},
                {1'b0, 1'b1, 2'(k % 3 + 1), 1'(k >= 48), 1'(k >= 48 && k < 84), 5'((k / 3 + 1) % 32), 1'(k == 95)});
        end
        tick();
        chk("t1_wait", {out_valid, out_code, out_last, in_ready}, {1'b0, 2'd0, 1'b0, PF});
        bdu_done = 1'b1;
        tick();
        bdu_done = 1'b0;
        chk("t1_done", {in_ready, out_valid, timeout_err}, {1'b1, 1'b0, 1'b0});
        chk("t1_abort", abort_count, 16'd0);

        // Early abort on beat 10
        set_pair(32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFF0000, 0, 0, 0, 32'hCAFE0001, 16'h0002);
        ab_q = 11'b10101110101;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            tick();
            chk("t2_beat", {out_valid, out_code, out_q_bit, out_r_bit},
                {1'b1, 2'(k % 3 + 1), ab_q[k], 1'b0});
        end
        bdu_terminate = 1'b1;
        tick();
        bdu_terminate = 1'b0;
        chk("t2_abort", {out_valid, in_ready, abort_count}, {1'b0, 1'b1, 16'd1});
        tick();
        chk("t2_idle", {out_valid, in_ready, bdu_clear}, {1'b0, 1'b1, 1'b0});

        // Timeout when bdu_done never comes
        set_pair(1, 2, 3, 4, 5, 6, 32'h0000_0033, 16'h0003);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        run_beats("t3_beat", 0, 95);
        for (int c = 1; c <= 8; c++) begin
            tick();
            chk("t3_wait", {out_valid, in_ready, timeout_err}, {1'b0, PF, 1'b0});
        end
        tick();
        chk("t3_timeout", {out_valid, in_ready, timeout_err, abort_count}, {1'b0, 1'b1, 1'b1, 16'd1});

        // Terminate together with out_last is an abort, no WAIT_DONE
        set_pair(7, 7, 7, 7, 7, 7, 32'h44, 16'h0004);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        run_beats("t4_beat", 0, 95);
        bdu_terminate = 1'b1;
        tick();
        bdu_terminate = 1'b0;
        chk("t4_last_abort", {out_valid, in_ready, abort_count}, {1'b0, 1'b1, 16'd2});

        // Terminate while waiting for done is not an abort
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        run_beats("t5_beat", 0, 95);
        tick();
        bdu_terminate = 1'b1;
        tick();
        bdu_terminate = 1'b0;
        chk("t5_wait_term", {out_valid, in_ready, abort_count, timeout_err}, {1'b0, 1'b1, 16'd2, 1'b1});

`ifdef STREAMER_PREFETCH_EN
        // Back-to-back with pending buffer: no idle cycle between pairs
        set_pair(1, 1, 1, 1, 1, 1, 32'h000A_000A, 16'h00AA);
        in_valid = 1'b1;
        tick();
        set_pair(2, 2, 2, 2, 2, 2, 32'h000B_000B, 16'h00BB);
        chk("t6_clear_a", {bdu_clear, in_ready}, {1'b1, 1'b1});
        tick();
        in_valid = 1'b0;
        chk("t6_pending", {out_valid, out_code, in_ready, out_threshold}, {1'b1, 2'd1, 1'b0, 32'h000A_000A});
        run_beats("t6_beat_a", 1, 95);
        tick();
        bdu_done = 1'b1;
        tick();
        bdu_done = 1'b0;
        chk("t6_clear_b", {bdu_clear, out_valid, in_ready, out_threshold}, {1'b1, 1'b0, 1'b1, 32'h000B_000B});
        run_beats("t6_beat_b", 0, 95);
        tick();
        bdu_done = 1'b1;
        tick();
        bdu_done = 1'b0;
        chk("t6_idle", {bdu_clear, out_valid, in_ready}, {1'b0, 1'b0, 1'b1});
`else
        // Back-to-back without buffer: one idle cycle, then the (updated) second pair
        set_pair(1, 1, 1, 1, 1, 1, 32'h000A_000A, 16'h00AA);
        in_valid = 1'b1;
        tick();
        set_pair(2, 2, 2, 2, 2, 2, 32'h000B_000B, 16'h00BB);
        run_beats("t6_beat_a", 0, 95);
        chk("t6_busy", {in_ready, out_threshold}, {1'b0, 32'h000A_000A});
        tick();
        bdu_done = 1'b1;
        tick();
        bdu_done = 1'b0;
        chk("t6_idle_gap", {in_ready, out_valid, bdu_clear}, {1'b1, 1'b0, 1'b0});
        tick();
        in_valid = 1'b0;
        chk("t6_clear_b", {bdu_clear, out_valid, out_threshold, out_ref_id}, {1'b1, 1'b0, 32'h000B_000B, 16'h00BB});
        run_beats("t6_beat_b", 0, 95);
        tick();
        bdu_done = 1'b1;
        tick();
        bdu_done = 1'b0;
`endif

        // Reset at beat 40, then a fresh pair starts cleanly
        set_pair(32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 0, 32'h77, 16'h0007);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        run_beats("t7_beat", 0, 40);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t7_reset_ctl", {in_ready, bdu_clear, out_valid, out_q_bit, out_r_bit, out_code, out_b, out_last, timeout_err},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0});
        chk("t7_reset_cnt", {abort_count, out_threshold, out_ref_id}, 64'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t7_clear", {bdu_clear, out_valid, out_threshold}, {1'b1, 1'b0, 32'h77});
        tick();
        chk("t7_beat0", {out_valid, out_code, out_q_bit, out_r_bit, out_b, out_last},
            {1'b1, 2'd1, 1'b1, 1'b0, 5'd1, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
